// File: rtl/cache_arbiter_pkg.sv
// Shared types for the two-port cache-to-memory arbiter.
package cache_arbiter_pkg;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B, DONE} arb_state_t;
   typedef enum logic {PORT_A, PORT_B} arb_port_t;
endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of instruction-cache (A), data-cache (B) and physical-memory signals.
interface cache_arbiter_if;
   import cache_arbiter_pkg::*;

   logic              pmem_read_a;
   logic [ADDR_W-1:0] pmem_addr_a;
   logic [LINE_W-1:0] pmem_rdata_a;
   logic              pmem_resp_a;

   logic              pmem_read_b;
   logic              pmem_write_b;
   logic [ADDR_W-1:0] pmem_addr_b;
   logic [LINE_W-1:0] pmem_wdata_b;
   logic [LINE_W-1:0] pmem_rdata_b;
   logic              pmem_resp_b;

   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   // arbiter side
   modport slave (
      input  pmem_read_a, pmem_addr_a,
      output pmem_rdata_a, pmem_resp_a,
      input  pmem_read_b, pmem_write_b, pmem_addr_b, pmem_wdata_b,
      output pmem_rdata_b, pmem_resp_b,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   // caches plus memory side
   modport master (
      output pmem_read_a, pmem_addr_a,
      input  pmem_rdata_a, pmem_resp_a,
      output pmem_read_b, pmem_write_b, pmem_addr_b, pmem_wdata_b,
      input  pmem_rdata_b, pmem_resp_b,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache (A) and D-cache (B) line requests onto one physical memory port.
// Latency: strobe one cycle after grant; resp passed through combinationally; DONE gap after each resp.
// Backpressure: requests wait in IDLE until the current transaction and its DONE cycle finish.
module cache_arbiter
   import cache_arbiter_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   cache_arbiter_if.slave  bus
);

   arb_state_t        state, state_nxt;
   arb_port_t         last_grant, last_grant_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic              lat_write, lat_write_nxt;
   logic [LINE_W-1:0] lat_wdata, lat_wdata_nxt;

   logic req_a, req_b, serving;

   assign req_a   = bus.pmem_read_a;
   assign req_b   = bus.pmem_read_b | bus.pmem_write_b;
   assign serving = (state == SERVE_A) || (state == SERVE_B);

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      lat_addr_nxt   = lat_addr;
      lat_write_nxt  = lat_write;
      lat_wdata_nxt  = lat_wdata;
      case (state)
         IDLE: begin
            // B wins a tie only when A took the previous grant
            if (req_b && (!req_a || last_grant == PORT_A)) begin
               state_nxt     = SERVE_B;
               lat_addr_nxt  = bus.pmem_addr_b;
               lat_write_nxt = bus.pmem_write_b;
               lat_wdata_nxt = bus.pmem_wdata_b;
            end else if (req_a) begin
               state_nxt     = SERVE_A;
               lat_addr_nxt  = bus.pmem_addr_a;
               lat_write_nxt = 1'b0;
               lat_wdata_nxt = '0;
            end
         end
         SERVE_A: begin
            if (bus.pmem_resp) begin
               state_nxt      = DONE;
               last_grant_nxt = PORT_A;
            end
         end
         SERVE_B: begin
            if (bus.pmem_resp) begin
               state_nxt      = DONE;
               last_grant_nxt = PORT_B;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= PORT_A;
         lat_addr   <= '0;
         lat_write  <= 1'b0;
         lat_wdata  <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         lat_addr   <= lat_addr_nxt;
         lat_write  <= lat_write_nxt;
         lat_wdata  <= lat_wdata_nxt;
      end
   end

   // strobes derive from state only, so reset drops them without waiting for a clock
   assign bus.pmem_read    = serving & ~lat_write;
   assign bus.pmem_write   = serving &  lat_write;
   assign bus.pmem_address = lat_addr;
   assign bus.pmem_wdata   = lat_wdata;

   assign bus.pmem_resp_a  = (state == SERVE_A) & bus.pmem_resp;
   assign bus.pmem_resp_b  = (state == SERVE_B) & bus.pmem_resp;
   assign bus.pmem_rdata_a = bus.pmem_rdata;
   assign bus.pmem_rdata_b = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus a randomized transaction-level model.
module tb_cache_arbiter;

   logic clk;
   logic rst;
   cache_arbiter_if bus();

   cache_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors = 0;
   int miscompares = 0;

   int           mem_cnt  = 0;
   int           mem_lat  = 3;
   bit           rand_lat = 0;
   logic [255:0] mem_data = '0;

   typedef struct {
      bit           port_b;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } op_t;

   typedef struct {
      bit           rd;
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } btx_t;

   function automatic logic [255:0] rand_line();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // One clock: sample point is 2 time units after the rising edge; memory model answers here.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bus.pmem_read || bus.pmem_write) begin
         if (mem_cnt == 0 && rand_lat) mem_lat = $urandom_range(1, 5);
         if (mem_cnt == mem_lat - 1) begin
            mem_data       = rand_line();
            bus.pmem_rdata = mem_data;
            bus.pmem_resp  = 1'b1;
         end else begin
            bus.pmem_resp  = 1'b0;
         end
         mem_cnt++;
      end else begin
         bus.pmem_resp = 1'b0;
         mem_cnt = 0;
      end
      #1;
   endtask

   task automatic clear_inputs();
      bus.pmem_read_a  = 1'b0;
      bus.pmem_addr_a  = '0;
      bus.pmem_read_b  = 1'b0;
      bus.pmem_write_b = 1'b0;
      bus.pmem_addr_b  = '0;
      bus.pmem_wdata_b = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
      tick();
      tick();
      vectors++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_resp_a, bus.pmem_resp_b} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_strobes: got %b required 0000",
                  {bus.pmem_read, bus.pmem_write, bus.pmem_resp_a, bus.pmem_resp_b});
      end
      vectors++;
      if (bus.pmem_address !== 32'h0 || bus.pmem_wdata !== 256'h0) begin
         miscompares++;
         $display("FAIL reset_latch: addr %h wdata %h required zero", bus.pmem_address, bus.pmem_wdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_a_read();
      int n;
      logic ra;
      rand_lat = 0;
      mem_lat  = 3;
      bus.pmem_read_a = 1'b1;
      bus.pmem_addr_a = 32'h0000_0040;
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 32'h40) begin
         miscompares++;
         $display("FAIL a_read_strobe: rd %b wr %b addr %h required 1 0 00000040",
                  bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
      n = 0;
      ra = bus.pmem_resp_a;
      while (!ra && n < 10) begin
         tick();
         n++;
         ra = bus.pmem_resp_a;
         vectors++;
         if (bus.pmem_resp_b !== 1'b0 || bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h40) begin
            miscompares++;
            $display("FAIL a_read_hold: resp_b %b rd %b addr %h required 0 1 00000040",
                     bus.pmem_resp_b, bus.pmem_read, bus.pmem_address);
         end
      end
      vectors++;
      if (ra !== 1'b1 || n != 2) begin
         miscompares++;
         $display("FAIL a_read_latency: resp %b after %0d cycles required 1 after 2", ra, n);
      end
      vectors++;
      if (bus.pmem_rdata_a !== mem_data) begin
         miscompares++;
         $display("FAIL a_read_data: got %h required %h", bus.pmem_rdata_a, mem_data);
      end
      // request held into the DONE cycle must not be granted again
      tick();
      vectors++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_resp_a} !== 3'b000) begin
         miscompares++;
         $display("FAIL a_done_quiet: got %b required 000", {bus.pmem_read, bus.pmem_write, bus.pmem_resp_a});
      end
      bus.pmem_read_a = 1'b0;
      tick();
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
         miscompares++;
         $display("FAIL a_stale_regrant: rd %b wr %b required 0 0", bus.pmem_read, bus.pmem_write);
      end
   endtask

   task automatic test_contest();
      int n;
      logic rb, ra;
      mem_lat = 2;
      bus.pmem_read_a = 1'b1;
      bus.pmem_addr_a = 32'h100;
      bus.pmem_read_b = 1'b1;
      bus.pmem_addr_b = 32'h200;
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h200) begin
         miscompares++;
         $display("FAIL contest_first_b: rd %b addr %h required 1 00000200", bus.pmem_read, bus.pmem_address);
      end
      n = 0;
      rb = bus.pmem_resp_b;
      while (!rb && n < 10) begin
         tick();
         n++;
         rb = bus.pmem_resp_b;
      end
      vectors++;
      if (rb !== 1'b1 || bus.pmem_resp_a !== 1'b0 || bus.pmem_rdata_b !== mem_data) begin
         miscompares++;
         $display("FAIL contest_b_resp: resp_b %b resp_a %b required 1 0", rb, bus.pmem_resp_a);
      end
      bus.pmem_read_b = 1'b0;
      tick();
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b0) begin
         miscompares++;
         $display("FAIL contest_gap: rd %b required 0 during DONE/IDLE", bus.pmem_read);
      end
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h100) begin
         miscompares++;
         $display("FAIL contest_then_a: rd %b addr %h required 1 00000100", bus.pmem_read, bus.pmem_address);
      end
      n = 0;
      ra = bus.pmem_resp_a;
      while (!ra && n < 10) begin
         tick();
         n++;
         ra = bus.pmem_resp_a;
      end
      vectors++;
      if (ra !== 1'b1 || bus.pmem_resp_b !== 1'b0) begin
         miscompares++;
         $display("FAIL contest_a_resp: resp_a %b resp_b %b required 1 0", ra, bus.pmem_resp_b);
      end
      bus.pmem_read_a = 1'b0;
      tick();
      tick();
      // A served last, so a fresh tie goes to B
      bus.pmem_read_a = 1'b1;
      bus.pmem_addr_a = 32'h140;
      bus.pmem_read_b = 1'b1;
      bus.pmem_addr_b = 32'h240;
      tick();
      vectors++;
      if (bus.pmem_address !== 32'h240 || bus.pmem_read !== 1'b1) begin
         miscompares++;
         $display("FAIL contest_alternate: rd %b addr %h required 1 00000240", bus.pmem_read, bus.pmem_address);
      end
      n = 0;
      while (!bus.pmem_resp_b && n < 10) begin
         tick();
         n++;
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_rw_both();
      int n;
      logic rb;
      logic [255:0] wd;
      wd = {8{32'hDEAD_BEEF}};
      mem_lat = 3;
      bus.pmem_read_b  = 1'b1;
      bus.pmem_write_b = 1'b1;
      bus.pmem_addr_b  = 32'h0000_1000;
      bus.pmem_wdata_b = wd;
      tick();
      vectors++;
      if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== wd
          || bus.pmem_address !== 32'h1000) begin
         miscompares++;
         $display("FAIL rw_write_first: wr %b rd %b addr %h wdata %h", bus.pmem_write, bus.pmem_read,
                  bus.pmem_address, bus.pmem_wdata);
      end
      n = 0;
      rb = bus.pmem_resp_b;
      while (!rb && n < 10) begin
         tick();
         n++;
         rb = bus.pmem_resp_b;
         vectors++;
         if (bus.pmem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_no_read: rd %b required 0 during writeback", bus.pmem_read);
         end
      end
      vectors++;
      if (rb !== 1'b1) begin
         miscompares++;
         $display("FAIL rw_write_resp: resp_b %b required 1", rb);
      end
      bus.pmem_write_b = 1'b0;
      tick();
      tick();
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_address !== 32'h1000) begin
         miscompares++;
         $display("FAIL rw_refill: rd %b wr %b addr %h required 1 0 00001000",
                  bus.pmem_read, bus.pmem_write, bus.pmem_address);
      end
      n = 0;
      while (!bus.pmem_resp_b && n < 10) begin
         tick();
         n++;
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_drop();
      int n;
      logic ra;
      int grants;
      mem_lat = 4;
      bus.pmem_read_a = 1'b1;
      bus.pmem_addr_a = 32'h80;
      tick();
      bus.pmem_read_a = 1'b0;
      n = 0;
      ra = bus.pmem_resp_a;
      while (!ra && n < 10) begin
         tick();
         n++;
         ra = bus.pmem_resp_a;
         vectors++;
         if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h80) begin
            miscompares++;
            $display("FAIL drop_hold: rd %b addr %h required 1 00000080", bus.pmem_read, bus.pmem_address);
         end
      end
      vectors++;
      if (ra !== 1'b1 || n != 3) begin
         miscompares++;
         $display("FAIL drop_resp: resp_a %b after %0d required 1 after 3", ra, n);
      end
      grants = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.pmem_read || bus.pmem_write) grants++;
      end
      vectors++;
      if (grants != 0) begin
         miscompares++;
         $display("FAIL drop_idle: %0d strobe cycles after completion required 0", grants);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic ra;
      int resp_seen;
      mem_lat = 10;
      bus.pmem_read_b = 1'b1;
      bus.pmem_addr_b = 32'h2000;
      tick();
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1) begin
         miscompares++;
         $display("FAIL rstmid_serving: rd %b required 1", bus.pmem_read);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if ({bus.pmem_read, bus.pmem_write, bus.pmem_resp_b} !== 3'b000) begin
         miscompares++;
         $display("FAIL rstmid_async: got %b required 000", {bus.pmem_read, bus.pmem_write, bus.pmem_resp_b});
      end
      clear_inputs();
      resp_seen = 0;
      tick();
      if (bus.pmem_resp_b) resp_seen++;
      rst = 1'b0;
      tick();
      if (bus.pmem_resp_b) resp_seen++;
      vectors++;
      if (resp_seen != 0) begin
         miscompares++;
         $display("FAIL rstmid_no_resp: %0d resp_b pulses required 0", resp_seen);
      end
      mem_lat = 2;
      bus.pmem_read_a = 1'b1;
      bus.pmem_addr_a = 32'h44;
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h44) begin
         miscompares++;
         $display("FAIL rstmid_regrant: rd %b addr %h required 1 00000044", bus.pmem_read, bus.pmem_address);
      end
      n = 0;
      ra = bus.pmem_resp_a;
      while (!ra && n < 10) begin
         tick();
         n++;
         ra = bus.pmem_resp_a;
      end
      vectors++;
      if (ra !== 1'b1 || bus.pmem_rdata_a !== mem_data) begin
         miscompares++;
         $display("FAIL rstmid_a_resp: resp_a %b required 1 with memory data", ra);
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_spurious();
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.pmem_rdata = rand_line();
         bus.pmem_resp  = 1'b1;
         #1;
         vectors++;
         if ({bus.pmem_resp_a, bus.pmem_resp_b, bus.pmem_read, bus.pmem_write} !== 4'b0000) begin
            miscompares++;
            $display("FAIL spurious_resp: got %b required 0000",
                     {bus.pmem_resp_a, bus.pmem_resp_b, bus.pmem_read, bus.pmem_write});
         end
      end
      mem_lat = 1;
      bus.pmem_read_a = 1'b1;
      bus.pmem_addr_a = 32'h48;
      tick();
      vectors++;
      if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h48 || bus.pmem_resp_a !== 1'b1) begin
         miscompares++;
         $display("FAIL spurious_after: rd %b addr %h resp_a %b required 1 00000048 1",
                  bus.pmem_read, bus.pmem_address, bus.pmem_resp_a);
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_random();
      op_t  aops[$];
      btx_t btx[$];
      op_t  bops[$];
      op_t  exp_q[$];
      op_t  o, e;
      btx_t t;
      int   ia, ib, na, nb, n, b_phase;
      bit   turn_b;
      logic ra, rb;

      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
      rand_lat = 1;

      na = $urandom_range(6, 10);
      nb = $urandom_range(6, 10);
      for (int i = 0; i < na; i++) begin
         o.port_b = 0; o.wr = 0; o.addr = {$urandom_range(0, 32'hFFFF), 5'b0}; o.wdata = '0;
         aops.push_back(o);
      end
      for (int i = 0; i < nb; i++) begin
         case ($urandom_range(0, 2))
            0:       begin t.rd = 1; t.wr = 0; end
            1:       begin t.rd = 0; t.wr = 1; end
            default: begin t.rd = 1; t.wr = 1; end
         endcase
         t.addr  = {$urandom_range(0, 32'hFFFF), 5'b0};
         t.wdata = rand_line();
         btx.push_back(t);
         // writeback goes first, refill follows as its own memory op
         if (t.wr) begin o.port_b = 1; o.wr = 1; o.addr = t.addr; o.wdata = t.wdata; bops.push_back(o); end
         if (t.rd) begin o.port_b = 1; o.wr = 0; o.addr = t.addr; o.wdata = '0;      bops.push_back(o); end
      end

      // both caches keep a request pending, so grants alternate until one side runs dry
      turn_b = 1;
      ia = 0;
      ib = 0;
      while (ia < aops.size() || ib < bops.size()) begin
         if ((turn_b && ib < bops.size()) || ia >= aops.size()) begin
            exp_q.push_back(bops[ib]); ib++; turn_b = 0;
         end else begin
            exp_q.push_back(aops[ia]); ia++; turn_b = 1;
         end
      end

      ia = 0;
      ib = 0;
      b_phase = 0;
      bus.pmem_read_a  = 1'b1;
      bus.pmem_addr_a  = aops[0].addr;
      bus.pmem_read_b  = btx[0].rd;
      bus.pmem_write_b = btx[0].wr;
      bus.pmem_addr_b  = btx[0].addr;
      bus.pmem_wdata_b = btx[0].wdata;

      foreach (exp_q[i]) begin
         e = exp_q[i];
         n = 0;
         while (!(bus.pmem_read || bus.pmem_write) && n < 8) begin
            tick();
            n++;
         end
         vectors++;
         if (bus.pmem_address !== e.addr || bus.pmem_write !== e.wr || bus.pmem_read !== !e.wr
             || (e.wr && bus.pmem_wdata !== e.wdata)) begin
            miscompares++;
            $display("FAIL rand_op[%0d]: rd %b wr %b addr %h required rd %b wr %b addr %h", i,
                     bus.pmem_read, bus.pmem_write, bus.pmem_address, !e.wr, e.wr, e.addr);
         end
         n = 0;
         ra = bus.pmem_resp_a;
         rb = bus.pmem_resp_b;
         while (!(ra || rb) && n < 10) begin
            tick();
            n++;
            ra = bus.pmem_resp_a;
            rb = bus.pmem_resp_b;
         end
         vectors++;
         if (ra !== !e.port_b || rb !== e.port_b
             || (e.port_b ? bus.pmem_rdata_b : bus.pmem_rdata_a) !== mem_data) begin
            miscompares++;
            $display("FAIL rand_resp[%0d]: resp_a %b resp_b %b required %b %b", i, ra, rb, !e.port_b, e.port_b);
         end
         if (ra) begin
            ia++;
            bus.pmem_read_a = (ia < na);
            if (ia < na) bus.pmem_addr_a = aops[ia].addr;
         end
         if (rb) begin
            if (btx[ib].rd && btx[ib].wr && b_phase == 0) begin
               bus.pmem_write_b = 1'b0;
               b_phase = 1;
            end else begin
               ib++;
               b_phase = 0;
               if (ib < nb) begin
                  bus.pmem_read_b  = btx[ib].rd;
                  bus.pmem_write_b = btx[ib].wr;
                  bus.pmem_addr_b  = btx[ib].addr;
                  bus.pmem_wdata_b = btx[ib].wdata;
               end else begin
                  bus.pmem_read_b  = 1'b0;
                  bus.pmem_write_b = 1'b0;
               end
            end
         end
         tick();
      end
      rand_lat = 0;
      clear_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_a_read();
      test_contest();
      test_rw_both();
      test_drop();
      test_reset_mid();
      test_spurious();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
